// File: rtl/cpu_pkg.sv
// Shared MonoCPU types and constants used by the fetch stage.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // A fetch address must be word aligned and leave a full word inside the memory.
    function automatic logic addr_legal(input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] last_addr);
        return (addr[1:0] == 2'b00) && (addr <= last_addr);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer: DEPTH entries of {pc, inst}; flush overrides push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push_s, do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign rdata_o   = mem_q[head_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (do_pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (!flush_i && do_push_s) begin
                mem_q[tail_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MonoCPU fetch stage: owns the PC, pushes fetched words into the fetch buffer,
// handles redirects and latches a sticky fault on illegal fetch addresses.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] addr_im,
    input  logic [31:0] inst_im,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc4,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] LAST_ADDR = XLEN'(IMEM_BYTES - INST_BYTES);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INST_BYTES);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic            fault_q, fault_d;
    logic            push_s, pop_s, room_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    fetch_entry_t    head_s, wr_entry_s;

    assign pop_s      = !fifo_empty_s && dec_ready;
    assign room_s     = (fifo_count_s < CW'(DEPTH)) || (fifo_full_s && pop_s);
    assign wr_entry_s = '{pc: fetch_pc_q, inst: inst_im};

    // PC, FSM and fault next-state; a redirect overrides everything else.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        push_s     = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            if (addr_legal(redirect_pc, LAST_ADDR)) begin
                state_d = RUN;
                fault_d = 1'b0;
            end else begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (!halt && room_s) begin
                        if (addr_legal(fetch_pc_q, LAST_ADDR)) begin
                            push_s     = 1'b1;
                            fetch_pc_d = fetch_pc_q + PC_STEP;
                        end else begin
                            state_d    = FAULT;
                            fault_d    = 1'b1;
                            fault_pc_d = fetch_pc_q;
                        end
                    end else begin
                        push_s = 1'b0;
                    end
                end
                FAULT:   state_d = FAULT;
                default: begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = fetch_pc_q;
                end
            endcase
        end
    end

    // Stage state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Decode-side outputs read zero whenever the buffer is empty.
    assign addr_im   = fetch_pc_q;
    assign dec_valid = !fifo_empty_s;
    assign dec_inst  = fifo_empty_s ? 32'h0000_0000 : head_s.inst;
    assign dec_pc    = fifo_empty_s ? 32'h0000_0000 : head_s.pc;
    assign dec_pc4   = fifo_empty_s ? 32'h0000_0000 : head_s.pc + PC_STEP;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_im;
    logic [31:0] inst_im;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_inst, dec_pc, dec_pc4;
    logic        fault;
    logic [31:0] fault_pc;

    int checks   = 0;
    int failures = 0;
    int tag      = 0;

    typedef struct {
        logic        rs;
        logic        rv;
        logic [31:0] rpc;
        logic        hl;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        ef;
        logic [31:0] efpc;
    } vec_t;

    vec_t tbl [24];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (1024),
        .DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr_im        (addr_im),
        .inst_im        (inst_im),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_pc4        (dec_pc4),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {16'hC0DE, a[15:0]} ^ {a[7:0], 24'h000000};
    endfunction

    assign inst_im = imem(addr_im);

    function automatic vec_t mk(input logic rs, input logic rv, input logic [31:0] rpc,
                                input logic hl, input logic rdy, input logic ev,
                                input logic [31:0] epc, input logic [31:0] eaddr,
                                input logic ef, input logic [31:0] efpc);
        vec_t v;
        v.rs = rs; v.rv = rv; v.rpc = rpc; v.hl = hl; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ef = ef; v.efpc = efpc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", nm, tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        dec_ready = 1'b0;
        #2;
        chk("rst_addr", addr_im, 32'h0);
        chk("rst_valid", {31'b0, dec_valid}, 32'h0);
        chk("rst_inst", dec_inst, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Apply one cycle of inputs at the falling edge and check that cycle's outputs.
    task automatic cyc(input vec_t v);
        logic [31:0] xpc;
        if (v.rs) do_reset();
        @(negedge clk);
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        halt           = v.hl;
        dec_ready      = v.rdy;
        #1;
        xpc = v.ev ? v.epc : 32'h0;
        chk("dec_valid", {31'b0, dec_valid}, {31'b0, v.ev});
        chk("dec_pc", dec_pc, xpc);
        chk("dec_inst", dec_inst, v.ev ? imem(v.epc) : 32'h0);
        chk("dec_pc4", dec_pc4, v.ev ? v.epc + 32'd4 : 32'h0);
        chk("addr_im", addr_im, v.eaddr);
        chk("fault", {31'b0, fault}, {31'b0, v.ef});
        chk("fault_pc", fault_pc, v.efpc);
        tag++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", tag);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             rs   rv   rpc           hl   rdy  ev   epc           eaddr         ef   efpc
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 32'h0,      32'h0,      1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      32'h4,      1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h4,      32'h8,      1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h8,      32'hC,      1'b0, 32'h0);
        tbl[4]  = mk(1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 32'h0);
        tbl[5]  = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h0,      32'h4,      1'b0, 32'h0);
        tbl[6]  = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h0,      32'h8,      1'b0, 32'h0);
        tbl[7]  = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h0,      32'h8,      1'b0, 32'h0);
        tbl[8]  = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      32'h8,      1'b0, 32'h0);
        tbl[9]  = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h4,      32'hC,      1'b0, 32'h0);
        tbl[10] = mk(1'b0, 1'b1, 32'h40,     1'b0, 1'b1, 1'b1, 32'h8,      32'h10,     1'b0, 32'h0);
        tbl[11] = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 32'h0,      32'h40,     1'b0, 32'h0);
        tbl[12] = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h40,     32'h44,     1'b0, 32'h0);
        tbl[13] = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h44,     32'h48,     1'b0, 32'h0);
        tbl[14] = mk(1'b0, 1'b1, 32'h42,     1'b0, 1'b1, 1'b1, 32'h44,     32'h4C,     1'b0, 32'h0);
        tbl[15] = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 32'h0,      32'h42,     1'b1, 32'h42);
        tbl[16] = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 32'h0,      32'h42,     1'b1, 32'h42);
        tbl[17] = mk(1'b0, 1'b1, 32'h0,      1'b0, 1'b1, 1'b0, 32'h0,      32'h42,     1'b1, 32'h42);
        tbl[18] = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 32'h0,      32'h0,      1'b0, 32'h42);
        tbl[19] = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 32'h0,      32'h4,      1'b0, 32'h42);
        tbl[20] = mk(1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b1, 32'h4,      32'h8,      1'b0, 32'h42);
        tbl[21] = mk(1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h0,      32'h8,      1'b0, 32'h42);
        tbl[22] = mk(1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 1'b0, 32'h0,      32'h8,      1'b0, 32'h42);
        tbl[23] = mk(1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,      32'h8,      1'b0, 32'h42);

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i]);
        end

        // Asynchronous reset in mid-cycle with one entry buffered.
        @(negedge clk);
        dec_ready = 1'b0;
        #1;
        chk("pre_rst_valid", {31'b0, dec_valid}, 32'h1);
        chk("pre_rst_pc", dec_pc, 32'h8);
        #1 rst = 1'b1;
        #1;
        chk("async_valid", {31'b0, dec_valid}, 32'h0);
        chk("async_inst", dec_inst, 32'h0);
        chk("async_pc", dec_pc, 32'h0);
        chk("async_pc4", dec_pc4, 32'h0);
        chk("async_addr", addr_im, 32'h0);
        chk("async_fault_pc", fault_pc, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0));
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 32'h0));

        // Run sequentially to the top of memory, then stall so two entries sit buffered.
        for (int k = 0; k < 255; k++) begin
            cyc(mk(k == 0, 1'b0, 32'h0, 1'b0, 1'b1, k > 0, 32'(4 * (k - 1)), 32'(4 * k),
                   1'b0, 32'h0));
        end
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3F8, 32'h3FC, 1'b0, 32'h0));
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3F8, 32'h400, 1'b0, 32'h0));
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3F8, 32'h400, 1'b0, 32'h0));
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h3FC, 32'h400, 1'b1, 32'h400));
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h400, 1'b1, 32'h400));
        cyc(mk(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h400, 1'b1, 32'h400));
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,   1'b0, 32'h400));
        cyc(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h4,   1'b0, 32'h400));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
